// File: rtl/vport_pkg.sv
// Shared types, timing helpers and colour expansion for the
// framebuffer stream video port sink.
package vport_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ARMED,
        RUN
    } state_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        underrun;
        logic        sync_err;
    } vout_t;

    localparam int CNT_W      = 12;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    function automatic int tim_total(input int act, input int fp,
                                     input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic logic [23:0] rgb555_to_888(input logic [14:0] p);
        return {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters; flags active area, frame origin and
// raw (polarity-free) sync windows for the current pixel position.
module video_timing_gen
    import vport_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic clk,
    input  logic rst_n,
    output logic active,
    output logic first,
    output logic hs_raw,
    output logic vs_raw
);

    localparam int H_TOTAL = tim_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = tim_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign first  = (hcnt == '0) && (vcnt == '0);
    assign hs_raw = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_raw = (vcnt >= VS_BEG) && (vcnt < VS_END);

endmodule

// File: rtl/fb_stream_vport_sink.sv
// Scanline stream consumer: locks to frame start, paces pixel pulls
// with the raster and drives registered RGB888/HS/VS/DE.
module fb_stream_vport_sink
    import vport_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_D,
    parameter int          H_FP     = H_FP_D,
    parameter int          H_SYNC   = H_SYNC_D,
    parameter int          H_BP     = H_BP_D,
    parameter int          V_ACTIVE = V_ACTIVE_D,
    parameter int          V_FP     = V_FP_D,
    parameter int          V_SYNC   = V_SYNC_D,
    parameter int          V_BP     = V_BP_D,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic        iCLK,
    input  logic        iRESETn,
    input  logic        iFB_START,
    input  logic [14:0] iFB_RGB,
    input  logic        iFB_DATAVALID,
    output logic        oFB_READY,
    output logic [7:0]  oRED,
    output logic [7:0]  oGRN,
    output logic [7:0]  oBLU,
    output logic        oHS,
    output logic        oVS,
    output logic        oDE,
    output logic        oLOCKED,
    output logic        oUNDERRUN,
    output logic        oSYNC_ERR
);

    logic   active;
    logic   first;
    logic   hs_raw;
    logic   vs_raw;
    state_t state;
    state_t state_nxt;
    logic   ready;
    vout_t  vout_nxt;
    vout_t  vout_q;
    logic [23:0] pix888;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (iCLK),
        .rst_n  (iRESETn),
        .active (active),
        .first  (first),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw)
    );

    assign pix888 = rgb555_to_888(iFB_RGB);

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    // Default view of a position is fill in active area, black in blanking.
    always_comb begin
        state_nxt         = state;
        ready             = 1'b0;
        vout_nxt          = '0;
        vout_nxt.de       = active;
        vout_nxt.hs       = hs_raw ? HS_POL : ~HS_POL;
        vout_nxt.vs       = vs_raw ? VS_POL : ~VS_POL;
        vout_nxt.rgb      = active ? FILL_RGB : 24'h000000;
        case (state)
            WAIT_SOF: begin
                ready = ~iFB_START;
                if (iFB_DATAVALID && iFB_START) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (first) begin
                    ready = 1'b1;
                    if (iFB_DATAVALID && iFB_START) begin
                        vout_nxt.rgb = pix888;
                        state_nxt    = RUN;
                    end else begin
                        state_nxt = WAIT_SOF;
                    end
                end
            end
            RUN: begin
                ready = active & ~(iFB_START & ~first);
                if (active) begin
                    if (!iFB_DATAVALID) begin
                        vout_nxt.underrun = 1'b1;
                    end else if (first) begin
                        vout_nxt.rgb = pix888;
                        if (!iFB_START) begin
                            vout_nxt.sync_err = 1'b1;
                            state_nxt         = WAIT_SOF;
                        end
                    end else if (iFB_START) begin
                        // Early start: hold it for the next frame origin.
                        vout_nxt.sync_err = 1'b1;
                        state_nxt         = ARMED;
                    end else begin
                        vout_nxt.rgb = pix888;
                    end
                end
            end
            default: begin
                state_nxt = WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            vout_q          <= '0;
            vout_q.hs       <= ~HS_POL;
            vout_q.vs       <= ~VS_POL;
        end else begin
            vout_q <= vout_nxt;
        end
    end

    assign oFB_READY = ready;
    assign oRED      = vout_q.rgb[23:16];
    assign oGRN      = vout_q.rgb[15:8];
    assign oBLU      = vout_q.rgb[7:0];
    assign oHS       = vout_q.hs;
    assign oVS       = vout_q.vs;
    assign oDE       = vout_q.de;
    assign oLOCKED   = (state == RUN);
    assign oUNDERRUN = vout_q.underrun;
    assign oSYNC_ERR = vout_q.sync_err;

endmodule

// File: tb/tb_fb_stream_vport_sink.sv
// Directed bench for the stream video port sink on a 14x7 raster
// (H 8/2/2/2, V 4/1/1/1) with a second instance at inverted sync polarity.
module tb_fb_stream_vport_sink;

    localparam int HT = 14;
    localparam int FR = 98;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fb_start;
    logic [14:0] fb_rgb;
    logic        fb_dv;

    logic        ready, hs, vs, de, locked, underrun, sync_err;
    logic [7:0]  red, grn, blu;
    logic        ready2, hs2, vs2, de2, locked2, underrun2, sync_err2;
    logic [7:0]  red2, grn2, blu2;
    logic [23:0] rgb;

    int   total = 0;
    int   bad = 0;
    int   p = 0;
    logic dv_en = 1'b0;
    logic xfer;

    assign rgb = {red, grn, blu};

    always #5 clk = ~clk;

    fb_stream_vport_sink #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FILL_RGB(24'h000000)
    ) dut (
        .iCLK(clk), .iRESETn(rst_n), .iFB_START(fb_start),
        .iFB_RGB(fb_rgb), .iFB_DATAVALID(fb_dv), .oFB_READY(ready),
        .oRED(red), .oGRN(grn), .oBLU(blu),
        .oHS(hs), .oVS(vs), .oDE(de), .oLOCKED(locked),
        .oUNDERRUN(underrun), .oSYNC_ERR(sync_err)
    );

    fb_stream_vport_sink #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FILL_RGB(24'h000000)
    ) dut2 (
        .iCLK(clk), .iRESETn(rst_n), .iFB_START(fb_start),
        .iFB_RGB(fb_rgb), .iFB_DATAVALID(fb_dv), .oFB_READY(ready2),
        .oRED(red2), .oGRN(grn2), .oBLU(blu2),
        .oHS(hs2), .oVS(vs2), .oDE(de2), .oLOCKED(locked2),
        .oUNDERRUN(underrun2), .oSYNC_ERR(sync_err2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] pix(input int n);
        case (n % 32)
            3:       return 15'h7FFF;
            4:       return 15'h4210;
            default: return 15'((n * 1237 + 11) % 32768);
        endcase
    endfunction

    function automatic logic [23:0] x888(input logic [14:0] v);
        return {v[14:10], v[14:12], v[9:5], v[9:7], v[4:0], v[4:2]};
    endfunction

    function automatic logic [23:0] exp_pix(input int n);
        case (n % 32)
            3:       return 24'hFFFFFF;
            4:       return 24'h848484;
            default: return x888(pix(n));
        endcase
    endfunction

    function automatic logic is_act(input int c);
        return ((c % HT) < 8) && ((c / HT) < 4);
    endfunction

    task automatic drive();
        fb_dv    = dv_en;
        fb_rgb   = pix(p);
        fb_start = (p % 32 == 0);
    endtask

    task automatic step();
        xfer = fb_dv & ready & rst_n;
        @(posedge clk);
        #1;
        if (xfer) p++;
    endtask

    task automatic chk_sync(input int c);
        int h;
        int v;
        h = c % HT;
        v = c / HT;
        check("hs", hs, !(h == 10 || h == 11));
        check("vs", vs, v != 5);
        check("hs_pol1", hs2, h == 10 || h == 11);
        check("vs_pol1", vs2, v == 5);
    endtask

    task automatic chk_reset_vals();
        check("rst_de", de, 0);
        check("rst_rgb", rgb, 0);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_hs_pol1", hs2, 0);
        check("rst_vs_pol1", vs2, 0);
        check("rst_locked", locked, 0);
        check("rst_underrun", underrun, 0);
        check("rst_sync_err", sync_err, 0);
    endtask

    // Not locked: npre non-start pixels drained, then START held.
    task automatic armed_frame(input int npre, input int pexp);
        for (int c = 0; c < FR; c++) begin
            dv_en = 1'b1;
            drive();
            #1;
            if (c == npre) check("p_at_sof", p, pexp);
            check("armed_ready", ready, c < npre);
            step();
            check("armed_rgb", rgb, 0);
            check("armed_de", de, is_act(c));
            check("armed_locked", locked, 0);
            check("armed_underrun", underrun, 0);
            chk_sync(c);
        end
    endtask

    // Locked frame; optional DATAVALID dropout of dn pixels on line dl.
    task automatic run_frame(input int base, input int dl, input int dh0,
                             input int dn);
        int slip;
        int h;
        int v;
        logic a;
        logic drop;
        logic [23:0] e;
        slip = 0;
        for (int c = 0; c < FR; c++) begin
            h    = c % HT;
            v    = c / HT;
            a    = is_act(c);
            drop = a && (v == dl) && (h >= dh0) && (h < dh0 + dn);
            dv_en = !drop;
            drive();
            #1;
            check("run_ready", ready, a);
            step();
            if (a && !drop) e = exp_pix(base + v * 8 + h - slip);
            else e = 24'h000000;
            check("run_rgb", rgb, e);
            check("run_de", de, a);
            check("run_locked", locked, 1);
            check("run_underrun", underrun, drop);
            check("run_sync_err", sync_err, 0);
            chk_sync(c);
            if (drop) slip++;
        end
    endtask

    // Slipped stream: non-start pixel lands on the frame origin.
    task automatic resync_frame(input int pexp);
        for (int c = 0; c < FR; c++) begin
            dv_en = 1'b1;
            drive();
            #1;
            if (c == 0) check("p_slip", p, pexp);
            check("resync_ready", ready, c <= 2);
            step();
            check("resync_rgb", rgb, (c == 0) ? x888(pix(pexp)) : 24'h0);
            check("resync_de", de, is_act(c));
            check("resync_sync_err", sync_err, c == 0);
            check("resync_locked", locked, 0);
            check("resync_underrun", underrun, 0);
        end
    endtask

    // START shows up early at line 2, pixel 0.
    task automatic early_frame(input int base, input int jump);
        int h;
        int v;
        logic a;
        for (int c = 0; c < FR; c++) begin
            h = c % HT;
            v = c / HT;
            a = is_act(c);
            dv_en = 1'b1;
            if (c == 2 * HT) p = jump;
            drive();
            #1;
            check("early_ready", ready, a && (c < 2 * HT));
            step();
            if (c < 2 * HT) begin
                check("early_rgb", rgb, a ? exp_pix(base + v * 8 + h) : 24'h0);
                check("early_locked", locked, 1);
            end else begin
                check("early_rgb_fill", rgb, 0);
                check("early_locked", locked, 0);
            end
            check("early_sync_err", sync_err, c == 2 * HT);
            check("early_de", de, a);
        end
    endtask

    initial begin
        dv_en = 1'b0;
        p     = 0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;
        armed_frame(0, 0);
        run_frame(0, -1, 0, 0);
        run_frame(32, 1, 3, 3);
        resync_frame(61);
        run_frame(64, -1, 0, 0);
        early_frame(96, 128);
        run_frame(128, -1, 0, 0);
        // Locked again; reset at hcnt=5 of line 2.
        for (int c = 0; c < 2 * HT + 5; c++) begin
            dv_en = 1'b1;
            drive();
            #1;
            step();
        end
        check("pre_rst_de", de, 1);
        check("pre_rst_locked", locked, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        dv_en = 1'b0;
        drive();
        repeat (3) step();
        p = 155;
        rst_n = 1'b1;
        armed_frame(5, 160);
        run_frame(160, -1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
